version_store_writer: RTL and testbench

//  Write side of the multi-version store: accepts data words over a valid/ready handshake and

---
 rtl/version_store_writer_if.sv | 27 ++
 rtl/version_store_writer.sv | 161 ++++++++++++++++
 tb/tb_version_store_writer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/version_store_writer_if.sv
// Write handshake plus packed slot buses between the version store writer and its users.
// Slot i occupies [i*VERSION_WIDTH +: VERSION_WIDTH] of versions and [i*DATA_WIDTH +: DATA_WIDTH] of dataOutputs.
// wrReady is driven from registered state only and never depends on wrValid.
interface version_store_writer_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int VERSION_WIDTH = 4,
    parameter int VERSION_NUM   = 4
);
    logic                                 wrValid;
    logic [DATA_WIDTH-1:0]                wrData;
    logic                                 wrReady;
    logic [VERSION_WIDTH*VERSION_NUM-1:0] versions;
    logic [DATA_WIDTH*VERSION_NUM-1:0]    dataOutputs;
    logic [VERSION_NUM-1:0]               validMask;
    logic [VERSION_WIDTH-1:0]             currentVer;
    logic                                 busy;

    modport master (
        output wrValid, wrData,
        input  wrReady, versions, dataOutputs, validMask, currentVer, busy
    );

    modport slave (
        input  wrValid, wrData,
        output wrReady, versions, dataOutputs, validMask, currentVer, busy
    );
endinterface

// File: rtl/version_store_writer.sv
// Stamps accepted words with increasing versions into free/oldest slots; optional clear via VERSION_STORE_CLEAR_EN.
// Latency: accepted write visible on the slot buses one cycle later.
// Backpressure: wrReady low for 2*VERSION_NUM cycles while versions are renormalised after an overflowing write.
module version_store_writer #(
    parameter int DATA_WIDTH    = 32,
    parameter int VERSION_WIDTH = 4,
    parameter int VERSION_NUM   = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef VERSION_STORE_CLEAR_EN
    input  logic clear,
`endif
    version_store_writer_if.slave bus
);
    localparam int IDX_W = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1;
    localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(VERSION_NUM - 1);
    localparam logic [IDX_W-1:0]         IDX_ONE  = IDX_W'(1);
    localparam logic [VERSION_WIDTH-1:0] VER_ONE  = VERSION_WIDTH'(1);
    localparam logic [VERSION_WIDTH-1:0] VER_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [VERSION_WIDTH-1:0] min_q, min_d;
    logic [VERSION_WIDTH-1:0] base_q, base_d;
    logic [VERSION_WIDTH-1:0] cur_q, cur_d;
    logic [VERSION_WIDTH-1:0] ver_q [VERSION_NUM];
    logic [VERSION_WIDTH-1:0] ver_d [VERSION_NUM];
    logic [DATA_WIDTH-1:0]    dat_q [VERSION_NUM];
    logic [DATA_WIDTH-1:0]    dat_d [VERSION_NUM];
    logic [VERSION_NUM-1:0]   valid_q, valid_d;

    logic                     clear_w;
    logic                     wr_ready;
    logic                     accept;
    logic [IDX_W-1:0]         tgt;
    logic                     tgt_found;
    logic [VERSION_WIDTH-1:0] tgt_min;
    logic [VERSION_WIDTH-1:0] new_ver;
    logic [VERSION_WIDTH-1:0] scan_min;

`ifdef VERSION_STORE_CLEAR_EN
    assign clear_w = clear;
`else
    assign clear_w = 1'b0;
`endif

    assign wr_ready = (state_q == IDLE) && !clear_w;
    assign accept   = bus.wrValid && wr_ready;
    assign new_ver  = cur_q + VER_ONE;
    assign scan_min = (valid_q[idx_q] && (ver_q[idx_q] < min_q)) ? ver_q[idx_q] : min_q;

    // Lowest free slot wins; with no free slot, the oldest (smallest, unique) version is evicted.
    always_comb begin
        tgt       = '0;
        tgt_found = 1'b0;
        tgt_min   = ver_q[0];
        for (int i = 0; i < VERSION_NUM; i++) begin
            if (!valid_q[i] && !tgt_found) begin
                tgt       = IDX_W'(i);
                tgt_found = 1'b1;
            end
        end
        if (!tgt_found) begin
            for (int i = 1; i < VERSION_NUM; i++) begin
                if (ver_q[i] < tgt_min) begin
                    tgt_min = ver_q[i];
                    tgt     = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        min_d   = min_q;
        base_d  = base_q;
        cur_d   = cur_q;
        ver_d   = ver_q;
        dat_d   = dat_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (clear_w) begin
                    ver_d   = '{default: '0};
                    dat_d   = '{default: '0};
                    valid_d = '0;
                    cur_d   = '0;
                end else if (accept) begin
                    ver_d[tgt]   = new_ver;
                    dat_d[tgt]   = bus.wrData;
                    valid_d[tgt] = 1'b1;
                    cur_d        = new_ver;
                    if (new_ver == VER_MAX) begin
                        state_d = SCAN;
                        idx_d   = '0;
                        min_d   = VER_MAX;
                    end
                end
            end
            SCAN: begin
                min_d = scan_min;
                if (idx_q == IDX_LAST) begin
                    base_d  = scan_min - VER_ONE;
                    state_d = SHIFT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            SHIFT: begin
                if (valid_q[idx_q]) begin
                    ver_d[idx_q] = ver_q[idx_q] - base_q;
                end
                if (idx_q == IDX_LAST) begin
                    cur_d   = cur_q - base_q;
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            min_q   <= '0;
            base_q  <= '0;
            cur_q   <= '0;
            ver_q   <= '{default: '0};
            dat_q   <= '{default: '0};
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            min_q   <= min_d;
            base_q  <= base_d;
            cur_q   <= cur_d;
            ver_q   <= ver_d;
            dat_q   <= dat_d;
            valid_q <= valid_d;
        end
    end

    for (genvar g = 0; g < VERSION_NUM; g++) begin : g_out
        assign bus.versions[g*VERSION_WIDTH +: VERSION_WIDTH] = ver_q[g];
        assign bus.dataOutputs[g*DATA_WIDTH +: DATA_WIDTH]    = dat_q[g];
    end

    assign bus.wrReady    = wr_ready;
    assign bus.validMask  = valid_q;
    assign bus.currentVer = cur_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_version_store_writer.sv
// Directed bench: writes push expected slot contents into a scoreboard, a negedge monitor pops and compares.
module tb_version_store_writer;
    localparam int DW = 32;
    localparam int VW = 4;
    localparam int VN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef VERSION_STORE_CLEAR_EN
    logic clear = 1'b0;
`endif

    version_store_writer_if #(.DATA_WIDTH(DW), .VERSION_WIDTH(VW), .VERSION_NUM(VN)) bus ();

    version_store_writer #(.DATA_WIDTH(DW), .VERSION_WIDTH(VW), .VERSION_NUM(VN)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef VERSION_STORE_CLEAR_EN
        .clear(clear),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          slot;
        logic [3:0]  ver;
        logic [31:0] dat;
        logic [3:0]  mask;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_pending = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dv(input int n);
        return 32'hDA7A_0000 + 32'(n);
    endfunction

    // Monitor: a write is accepted at the posedge following a negedge where valid && ready.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_pending) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: accepted write with no expected entry");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_ver",  128'(bus.versions[mon_e.slot*VW +: VW]),    128'(mon_e.ver));
                    chk("wr_data", 128'(bus.dataOutputs[mon_e.slot*DW +: DW]), 128'(mon_e.dat));
                    chk("wr_cur",  128'(bus.currentVer), 128'(mon_e.ver));
                    chk("wr_mask", 128'(bus.validMask),  128'(mon_e.mask));
                end
            end
            mon_pending = !rst && bus.wrValid && bus.wrReady;
        end
    end

    // Called at a negedge; returns at the negedge after acceptance with wrValid still high.
    task automatic wr(input logic [31:0] d, input int slot, input logic [3:0] ver, input logic [3:0] mask);
        int guard = 0;
        exp_q.push_back('{slot, ver, d, mask});
        bus.wrValid = 1'b1;
        bus.wrData  = d;
        while (!bus.wrReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.wrReady) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: wrReady got 0 expected 1 within 50 cycles");
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_versions"}, 128'(bus.versions),    128'h0);
        chk({tag, "_data"},     128'(bus.dataOutputs), 128'h0);
        chk({tag, "_mask"},     128'(bus.validMask),   128'h0);
        chk({tag, "_cur"},      128'(bus.currentVer),  128'h0);
        chk({tag, "_busy"},     128'(bus.busy),        128'h0);
        chk({tag, "_ready"},    128'(bus.wrReady),     128'h1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wrValid = 1'b0;
        bus.wrData  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_state("rst1");

        wr(dv(1), 0, 4'd1, 4'b0001);
        wr(dv(2), 1, 4'd2, 4'b0011);
        wr(dv(3), 2, 4'd3, 4'b0111);
        bus.wrValid = 1'b0;
        chk("abc_versions", 128'(bus.versions), 128'h0321);
        chk("abc_slot3_data", 128'(bus.dataOutputs[127:96]), 128'h0);
        chk("abc_mask", 128'(bus.validMask), 128'b0111);
        chk("abc_cur", 128'(bus.currentVer), 128'd3);

        wr(dv(4), 3, 4'd4, 4'hF);
        wr(dv(5), 0, 4'd5, 4'hF);
        wr(dv(6), 1, 4'd6, 4'hF);
        bus.wrValid = 1'b0;
        chk("evict_versions", 128'(bus.versions), 128'h4365);
        chk("evict_data", 128'(bus.dataOutputs), {dv(4), dv(3), dv(6), dv(5)});
        chk("evict_mask", 128'(bus.validMask), 128'hF);

        // Eviction rotates through slots 2,3,0,1 from write 7 onward.
        for (int k = 7; k <= 15; k++) wr(dv(k), (k - 5) % 4, 4'(k), 4'hF);

        // Write 16 is held during renormalisation and must be taken only once ready returns.
        bus.wrValid = 1'b1;
        bus.wrData  = dv(16);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_busy",  128'(bus.busy),    128'h1);
            chk("ovf_ready", 128'(bus.wrReady), 128'h0);
            chk("ovf_data_hold", 128'(bus.dataOutputs), {dv(12), dv(15), dv(14), dv(13)});
            @(negedge clk);
        end
        chk("renorm_ready", 128'(bus.wrReady), 128'h1);
        chk("renorm_busy", 128'(bus.busy), 128'h0);
        chk("renorm_versions", 128'(bus.versions), 128'h1432);
        chk("renorm_cur", 128'(bus.currentVer), 128'd4);
        wr(dv(16), 3, 4'd5, 4'hF);
        bus.wrValid = 1'b0;
        chk("w16_versions", 128'(bus.versions), 128'h5432);

        // Second overflow; reset lands in the third SHIFT cycle.
        for (int k = 0; k < 10; k++) wr(dv(20 + k), k % 4, 4'(6 + k), 4'hF);
        bus.wrValid = 1'b0;
        repeat (6) @(negedge clk);
        chk("partial_shift_versions", 128'(bus.versions), 128'hDC43);
        chk("partial_shift_busy", 128'(bus.busy), 128'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("rst2");

        wr(dv(30), 0, 4'd1, 4'b0001);
        wr(dv(31), 1, 4'd2, 4'b0011);
        wr(dv(32), 2, 4'd3, 4'b0111);
        bus.wrValid = 1'b0;

`ifdef VERSION_STORE_CLEAR_EN
        clear       = 1'b1;
        bus.wrValid = 1'b1;
        bus.wrData  = dv(33);
        chk("clr_ready", 128'(bus.wrReady), 128'h0);
        @(negedge clk);
        clear       = 1'b0;
        bus.wrValid = 1'b0;
        chk("clr_mask", 128'(bus.validMask), 128'h0);
        chk("clr_cur", 128'(bus.currentVer), 128'h0);
        chk("clr_versions", 128'(bus.versions), 128'h0);
        chk("clr_data", 128'(bus.dataOutputs), 128'h0);
        wr(dv(34), 0, 4'd1, 4'b0001);
        bus.wrValid = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("sb_drain", 128'(exp_q.size()), 128'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
